vector_op_sequencer: RTL
========================

Name: vector_op_sequencer

Overview:
- Upstream issue stage for the scalar integer ALU (`opcode`/`a`/`b` in, registered `result` out one clock later).
- Holds two operand vectors in internal buffers and issues one element pair per cycle to the ALU, with the same opcode for every element.
- Writes the returned ALU results into a result buffer that the host reads by index.
- Turns the scalar ALU into an element-wise vector ADD/MULT engine.

Parameters:
- DEPTH, 16, number of elements per operand/result buffer.
- IDX_W, 4, index width; equals clog2(DEPTH).
- LEN_W, 5, vector length field width; equals clog2(DEPTH+1).
- ALU_LAT, 1, ALU input-to-result register latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_we  in  1  load strobe for the operand buffers.
- ld_idx  in  IDX_W  element index to load.
- ld_a  in  32  operand A element.
- ld_b  in  32  operand B element.
- start  in  1  command strobe.
- start_op  in  8  opcode: 8'h01 = ADD, 8'h02 = MULT.
- start_len  in  LEN_W  number of elements to process.
- busy  out  1  high while a command is in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.
- rd_idx  in  IDX_W  result read index.
- rd_data  out  32  result buffer[rd_idx], combinational read.
- alu_opcode  out  8  to the ALU `opcode` input.
- alu_a  out  32  to the ALU `a` input.
- alu_b  out  32  to the ALU `b` input.
- alu_result  in  32  from the ALU `result` output.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, err=0.
  - alu_opcode=0, alu_a=0, alu_b=0.
  - Issue index=0; writeback tag pipeline cleared.
  - All A/B/result buffer entries =0.
  - Reset mid-command aborts it: no done pulse; partially written results are cleared.
- Loading:
  - ld_we=1 in IDLE writes A[ld_idx]=ld_a and B[ld_idx]=ld_b at the edge.
  - ld_we while busy is ignored.
- Start acceptance:
  - Accepted only in IDLE, with start_op in {01,02} and 1<=start_len<=DEPTH.
  - Accepting edge E0: latch op and len, idx=0, state -> ISSUE, busy=1.
  - A start that fails any of these conditions in IDLE gives err=1 for the next cycle only; state stays IDLE.
  - start while busy is ignored silently (no err).
- States: IDLE, ISSUE, DRAIN.
  - ISSUE, each edge:
    - alu_opcode<=op, alu_a<=A[idx], alu_b<=B[idx].
    - Push tag {valid=1, idx} into the writeback pipeline; idx++.
    - After the edge that issues element len-1 -> DRAIN.
  - DRAIN: alu_opcode<=0, alu_a<=0, alu_b<=0; push invalid tags.
  - Return to IDLE when the last valid tag retires.
- Writeback:
  - The tag pipeline has ALU_LAT+1 stages, because alu_* are registered here and the ALU registers again.
  - When the tag leaving the pipeline is valid: result[tag.idx] <= alu_result on that edge.
  - Element i is issued at edge E0+1+i and written at edge E0+2+ALU_LAT+i.
- Completion:
  - done=1 and busy=0 are set on the same edge that writes element len-1 (E0+len+1+ALU_LAT).
  - State is IDLE in that cycle; done drops after one cycle.
  - A new start is accepted in the cycle done is high.
- Ordering and arithmetic:
  - Exactly one element per cycle, no bubbles, in index order.
  - Arithmetic is the ALU's: results wrap mod 2^32 (low 32 bits of the product).
  - The ALU `done` output is not used; timing is fixed by ALU_LAT.
- Result buffer access:
  - The result buffer keeps its values until overwritten or reset.
  - Entries >= len from earlier commands are untouched.
  - rd_data during busy may return old or new values.
- Simultaneous events: ld_we and start on the same IDLE edge → the load is performed AND the start is accepted. Issue reads buffers from the next edge on, so the loaded value is used.

Test Plan:
- Load A={1,2,3,4}, B={10,20,30,40}; start op=01, len=4:
  - busy high for 6 cycles; done pulses once at E0+6.
  - rd result[0..3]={11,22,33,44}.
  - alu_opcode=01 on exactly 4 consecutive cycles.
- MULT with wrap: A[0]=32'h0001_0000, B[0]=32'h0001_0000, A[1]=7, B[1]=6; op=02, len=2 → result={0, 42}; done at E0+4.
- Rejections, with no busy and no ALU activity in each case:
  - op=03, len=2 → err pulses for one cycle.
  - len=0 → err.
  - len=17 → err.
- start pulsed again while busy → ignored. The first command completes normally; exactly one done pulse; no err.
- Boundary: len=DEPTH=16 with A[i]=i, B[i]=2i, op=01 → result[i]=3i for all i; done at E0+18. Back-to-back start in the done cycle is accepted.
- Reset mid-command: deassert rst_n at E0+3 of a len=8 command:
  - all outputs go to 0 immediately and no done pulse follows.
  - every rd_data reads 0 after reset release.

Source files
------------

// File: rtl/vector_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_op_sequencer
// Purpose  : Issues element pairs from two operand buffers to a scalar ALU and
//            collects the results into a host-readable result buffer.
// Revision : 1.0  initial release
// ============================================================================
module vector_op_sequencer #(
   parameter int DEPTH   = 16,
   parameter int IDX_W   = 4,
   parameter int LEN_W   = 5,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_we,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [31:0]       ld_a,
   input  logic [31:0]       ld_b,
   input  logic              start,
   input  logic [7:0]        start_op,
   input  logic [LEN_W-1:0]  start_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [31:0]       rd_data,
   output logic [7:0]        alu_opcode,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   input  logic [31:0]       alu_result
);

   // One stage for the local alu_* register plus the ALU's own latency.
   localparam int c_nstg = ALU_LAT + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   logic [7:0]         r_op;
   logic [LEN_W-1:0]   r_len;
   logic [IDX_W-1:0]   r_idx;
   logic [c_nstg-1:0]  r_tag_v;
   logic [IDX_W-1:0]   r_tag_idx [c_nstg];
   logic [31:0]        r_a   [DEPTH];
   logic [31:0]        r_b   [DEPTH];
   logic [31:0]        r_res [DEPTH];

   logic               w_idle;
   logic               w_start_ok;
   logic               w_wb;
   logic [IDX_W-1:0]   w_wb_idx;
   logic               w_last_issue;
   logic               w_last_wb;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_start_ok   = ((start_op == 8'h01) || (start_op == 8'h02)) &&
                         (start_len != '0) && (start_len <= LEN_W'(DEPTH));
   assign w_wb         = r_tag_v[c_nstg-1];
   assign w_wb_idx     = r_tag_idx[c_nstg-1];
   assign w_last_issue = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
   assign w_last_wb    = w_wb && (LEN_W'(w_wb_idx) == (r_len - LEN_W'(1)));
   assign rd_data      = r_res[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         r_tag_v    <= '0;
         for (int s = 0; s < c_nstg; s++) r_tag_idx[s] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         for (int s = 1; s < c_nstg; s++) begin
            r_tag_v[s]   <= r_tag_v[s-1];
            r_tag_idx[s] <= r_tag_idx[s-1];
         end
         case (r_state)
            ST_IDLE: begin
               alu_opcode   <= '0;
               alu_a        <= '0;
               alu_b        <= '0;
               r_tag_v[0]   <= 1'b0;
               r_tag_idx[0] <= '0;
               if (start) begin
                  if (w_start_ok) begin
                     r_op    <= start_op;
                     r_len   <= start_len;
                     r_idx   <= '0;
                     busy    <= 1'b1;
                     r_state <= ST_ISSUE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               alu_opcode   <= r_op;
               alu_a        <= r_a[r_idx];
               alu_b        <= r_b[r_idx];
               r_tag_v[0]   <= 1'b1;
               r_tag_idx[0] <= r_idx;
               r_idx        <= r_idx + IDX_W'(1);
               if (w_last_issue) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               alu_opcode   <= '0;
               alu_a        <= '0;
               alu_b        <= '0;
               r_tag_v[0]   <= 1'b0;
               r_tag_idx[0] <= '0;
               if (w_last_wb) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operand loads and result writeback; the tag retiring this edge names its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_a[i]   <= '0;
            r_b[i]   <= '0;
            r_res[i] <= '0;
         end
      end else begin
         if (ld_we && w_idle) begin
            r_a[ld_idx] <= ld_a;
            r_b[ld_idx] <= ld_b;
         end
         if (w_wb) r_res[w_wb_idx] <= alu_result;
      end
   end

endmodule
`default_nettype wire
